// File: rtl/uib_pkg.sv
// Shared uib interconnect definitions: bus geometry and arbiter state encoding.
//   NMASTER_W  : log2 of the number of bus masters
//   NSLAVE_W   : log2 of the number of slaves
//   ADDR_W     : uib address width
//   arb_state_e: arbiter FSM states
package uib_pkg;

    localparam int unsigned NMASTER_W = 1;
    localparam int unsigned NSLAVE_W  = 2;
    localparam int unsigned ADDR_W    = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   i_req     : per-master request vector
//   i_last    : index of the previously served master
//   o_valid_c : at least one request is present
//   o_idx_c   : first requester scanning i_last+1, i_last+2, ... (mod 2**W)
module rr_pick #(
    parameter int unsigned W = 1
) (
    input  logic [(2**W)-1:0] i_req,
    input  logic [W-1:0]      i_last,
    output logic              o_valid_c,
    output logic [W-1:0]      o_idx_c
);

    localparam int unsigned N = 2**W;

    logic [W-1:0] w_cand;

    // Scan from farthest to nearest so the nearest requester after i_last wins;
    // offset N wraps to i_last itself, giving it the lowest priority.
    always_comb begin
        o_valid_c = |i_req;
        o_idx_c   = i_last;
        w_cand    = i_last;
        for (int i = N; i >= 1; i--) begin
            w_cand = i_last + W'(i);
            if (i_req[w_cand]) begin
                o_idx_c = w_cand;
            end
        end
    end

endmodule

// File: rtl/uib_arbiter.sv
// Round-robin uib bus arbiter with per-transaction grant lock and watchdog.
//   i_clk             : system clock
//   i_rst             : synchronous active-low reset
//   i_master_req      : per-master request, held until ready
//   i_slave_ready_sel : ready of the slave addressed by the current master
//   o_grant           : one-hot grant, zero when idle
//   o_curmaster       : index of granted master
//   o_busy            : high while a grant is held
//   o_timeout_err     : one-cycle pulse when the watchdog releases the bus
//   o_err_master      : master index captured at the last watchdog release
module uib_arbiter
    import uib_pkg::*;
#(
    parameter int unsigned NMASTER_W = uib_pkg::NMASTER_W,
    parameter int unsigned TO_W      = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [(2**NMASTER_W)-1:0] i_master_req,
    input  logic                      i_slave_ready_sel,
    output logic [(2**NMASTER_W)-1:0] o_grant,
    output logic [NMASTER_W-1:0]      o_curmaster,
    output logic                      o_busy,
    output logic                      o_timeout_err,
    output logic [NMASTER_W-1:0]      o_err_master
);

    localparam int unsigned NMASTER = 2**NMASTER_W;
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    arb_state_e           r_state;
    logic [NMASTER-1:0]   r_grant;
    logic [NMASTER_W-1:0] r_curmaster;
    logic                 r_busy;
    logic                 r_timeout_err;
    logic [NMASTER_W-1:0] r_err_master;
    logic [TO_W-1:0]      r_cnt;
    logic [NMASTER_W-1:0] r_last;

    arb_state_e           w_state_nxt;
    logic [NMASTER-1:0]   w_grant_nxt;
    logic [NMASTER_W-1:0] w_curmaster_nxt;
    logic                 w_busy_nxt;
    logic                 w_timeout_err_nxt;
    logic [NMASTER_W-1:0] w_err_master_nxt;
    logic [TO_W-1:0]      w_cnt_nxt;
    logic [NMASTER_W-1:0] w_last_nxt;

    logic [NMASTER_W-1:0] w_pick_last;
    logic                 w_pick_valid;
    logic [NMASTER_W-1:0] w_pick_idx;
    logic [NMASTER-1:0]   w_pick_onehot;

    // On completion the finishing master becomes "last" in the same cycle,
    // so the picker must see curmaster rather than the stale r_last.
    assign w_pick_last   = (r_state == GRANT) ? r_curmaster : r_last;
    assign w_pick_onehot = NMASTER'(1) << w_pick_idx;

    rr_pick #(
        .W (NMASTER_W)
    ) u_rr_pick (
        .i_req     (i_master_req),
        .i_last    (w_pick_last),
        .o_valid_c (w_pick_valid),
        .o_idx_c   (w_pick_idx)
    );

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_curmaster_nxt   = r_curmaster;
        w_busy_nxt        = r_busy;
        w_timeout_err_nxt = 1'b0;
        w_err_master_nxt  = r_err_master;
        w_cnt_nxt         = r_cnt;
        w_last_nxt        = r_last;

        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                if (w_pick_valid) begin
                    w_state_nxt     = GRANT;
                    w_grant_nxt     = w_pick_onehot;
                    w_curmaster_nxt = w_pick_idx;
                    w_busy_nxt      = 1'b1;
                    w_cnt_nxt       = '0;
                end
            end
            GRANT: begin
                if (i_slave_ready_sel) begin
                    // Completion: hand over back-to-back if anyone is waiting.
                    w_last_nxt = r_curmaster;
                    w_cnt_nxt  = '0;
                    if (w_pick_valid) begin
                        w_grant_nxt     = w_pick_onehot;
                        w_curmaster_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_busy_nxt  = 1'b0;
                    end
                end else if (!i_master_req[r_curmaster]) begin
                    w_last_nxt  = r_curmaster;
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end else if (r_cnt == TO_W'(TIMEOUT)) begin
                    w_timeout_err_nxt = 1'b1;
                    w_err_master_nxt  = r_curmaster;
                    w_last_nxt        = r_curmaster;
                    w_state_nxt       = IDLE;
                    w_grant_nxt       = '0;
                    w_busy_nxt        = 1'b0;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_curmaster   <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_master  <= '0;
            r_cnt         <= '0;
            r_last        <= '1;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_curmaster   <= w_curmaster_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_err_master  <= w_err_master_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last        <= w_last_nxt;
        end
    end

    assign o_grant       = r_grant;
    assign o_curmaster   = r_curmaster;
    assign o_busy        = r_busy;
    assign o_timeout_err = r_timeout_err;
    assign o_err_master  = r_err_master;

endmodule
